ipd_sample_sequencer: RTL

//  Sequences the truncating IPD servo controller (Solo_IPD_Truncamiento): sets the sample rate,

---
 rtl/ipd_sample_sequencer_if.sv | 42 ++++
 rtl/ipd_sample_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ipd_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ipd_sample_sequencer_if
//  Description : Bundle of the ADC-side, IPD-side and actuator-side signals
//                of the IPD sample sequencer. The master modport is the
//                sequencer; the slave modport is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ipd_sample_sequencer_if #(
    parameter int cant_bits = 13
);
    // Control and ADC side
    logic                        habilitar;
    logic                        adc_valid;
    logic signed [cant_bits-1:0] adc_dato;
    logic signed [cant_bits-1:0] ref_in;
    logic                        clr_overrun;

    // IPD operands, start pulse and result
    logic signed [cant_bits-1:0] pot_out;
    logic signed [cant_bits-1:0] ref_out;
    logic                        en_ipd;
    logic signed [cant_bits-1:0] salida_ipd;

    // Actuator command and status
    logic signed [cant_bits-1:0] u_out;
    logic                        u_valid;
    logic                        busy;
    logic                        overrun;
    logic                        sat;

    modport master (
        input  habilitar, adc_valid, adc_dato, ref_in, clr_overrun, salida_ipd,
        output pot_out, ref_out, en_ipd, u_out, u_valid, busy, overrun, sat
    );

    modport slave (
        output habilitar, adc_valid, adc_dato, ref_in, clr_overrun, salida_ipd,
        input  pot_out, ref_out, en_ipd, u_out, u_valid, busy, overrun, sat
    );
endinterface
`default_nettype wire

// File: rtl/ipd_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ipd_sample_sequencer
//  Description : Sample sequencer for the truncating IPD servo controller.
//                Generates the sample tick, captures one ADC reading and the
//                setpoint, pulses en_ipd for one cycle, waits the controller
//                latency and registers the result as the actuator command.
//                Optional output clamp enabled by defining SATURACION_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ipd_sample_sequencer #(
    parameter int                          cant_bits    = 13,
    parameter int                          DIV_MUESTREO = 1000,
    parameter int                          LATENCIA     = 15,
    parameter logic signed [cant_bits-1:0] U_MAX        = cant_bits'(2047),
    parameter logic signed [cant_bits-1:0] U_MIN        = cant_bits'(-2048)
) (
    input wire logic               clk,
    input wire logic               rst,
    ipd_sample_sequencer_if.master bus
);

`ifdef SATURACION_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    localparam int c_DIV_W = (DIV_MUESTREO > 1) ? $clog2(DIV_MUESTREO) : 1;
    localparam int c_LAT_W = (LATENCIA > 2) ? $clog2(LATENCIA) : 1;
    localparam logic [c_DIV_W-1:0] c_TICK_LAST = c_DIV_W'(DIV_MUESTREO - 1);
    // WAIT_LAT lasts LATENCIA-1 cycles so that u_valid lands LATENCIA+1
    // cycles after the en_ipd cycle.
    localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(LATENCIA - 2);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_WAIT_TICK = 3'd1;
    localparam logic [2:0] c_S_CAPTURE   = 3'd2;
    localparam logic [2:0] c_S_START     = 3'd3;
    localparam logic [2:0] c_S_WAIT_LAT  = 3'd4;
    localparam logic [2:0] c_S_LATCH     = 3'd5;

    logic [2:0]                  r_state;
    logic [c_DIV_W-1:0]          r_tick_cnt;
    logic [c_LAT_W-1:0]          r_lat_cnt;
    logic signed [cant_bits-1:0] r_pot_out;
    logic signed [cant_bits-1:0] r_ref_out;
    logic signed [cant_bits-1:0] r_u_out;
    logic                        r_en_ipd;
    logic                        r_u_valid;
    logic                        r_overrun;
    logic                        r_sat;

    logic                        w_tick;
    logic                        w_busy;
    logic                        w_hi;
    logic                        w_lo;
    logic signed [cant_bits-1:0] w_u_next;

    assign w_tick = bus.habilitar && (r_tick_cnt == c_TICK_LAST);
    assign w_busy = (r_state != c_S_IDLE) && (r_state != c_S_WAIT_TICK);

    // Clamp is forced off when the saturation option is not built in.
    assign w_hi     = c_SAT_EN && ($signed(bus.salida_ipd) > $signed(U_MAX));
    assign w_lo     = c_SAT_EN && ($signed(bus.salida_ipd) < $signed(U_MIN));
    assign w_u_next = w_hi ? U_MAX : (w_lo ? U_MIN : bus.salida_ipd);

    // Free-running sample divider, parked at zero while the loop is stopped.
    always_ff @(posedge clk) begin
        if (!rst || !bus.habilitar) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_DIV_W'(1);
        end
    end

    // Sticky overrun: a tick landing on a busy sequencer beats a clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_tick && w_busy) begin
            r_overrun <= 1'b1;
        end else if (bus.clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Sequencer FSM with registered operands, start pulse and command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_S_IDLE;
            r_lat_cnt <= '0;
            r_pot_out <= '0;
            r_ref_out <= '0;
            r_u_out   <= '0;
            r_en_ipd  <= 1'b0;
            r_u_valid <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_en_ipd  <= 1'b0;
            r_u_valid <= 1'b0;
            if (!bus.habilitar) begin
                r_state <= c_S_IDLE;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        r_state <= c_S_WAIT_TICK;
                    end
                    c_S_WAIT_TICK: begin
                        if (w_tick) begin
                            r_state <= c_S_CAPTURE;
                        end
                    end
                    c_S_CAPTURE: begin
                        if (bus.adc_valid) begin
                            r_pot_out <= bus.adc_dato;
                            r_ref_out <= bus.ref_in;
                            r_en_ipd  <= 1'b1;
                            r_state   <= c_S_START;
                        end
                    end
                    c_S_START: begin
                        r_lat_cnt <= '0;
                        r_state   <= c_S_WAIT_LAT;
                    end
                    c_S_WAIT_LAT: begin
                        if (r_lat_cnt == c_LAT_LAST) begin
                            r_state <= c_S_LATCH;
                        end else begin
                            r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
                        end
                    end
                    c_S_LATCH: begin
                        r_u_out   <= w_u_next;
                        r_sat     <= w_hi || w_lo;
                        r_u_valid <= 1'b1;
                        r_state   <= c_S_WAIT_TICK;
                    end
                    default: begin
                        r_state <= c_S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pot_out = r_pot_out;
    assign bus.ref_out = r_ref_out;
    assign bus.en_ipd  = r_en_ipd;
    assign bus.u_out   = r_u_out;
    assign bus.u_valid = r_u_valid;
    assign bus.busy    = w_busy;
    assign bus.overrun = r_overrun;
    assign bus.sat     = r_sat;

endmodule
`default_nettype wire
